dpram_stream_reader: RTL

- Read-side engine for the dual-port memory (64 x 8, 6-bit address, synchronous read). It attaches to port B.
- On a start pulse, it reads a contiguous run of words beginning at a base address. Addresses wrap modulo 64.
- The words are streamed out on a valid/ready interface, in address order, with backpressure.
- It pairs with the writer traffic on port A: a producer fills memory through port A, and this block drains it through port B.

---
 rtl/dpram_stream_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dpram_stream_reader.sv
// Port-B read engine: streams a contiguous, wrapping run of memory words out on valid/ready.
// Optional running-XOR checksum output enabled by defining DPRAM_STREAM_READER_CHECKSUM_EN.
module dpram_stream_reader #(
  parameter int AW        = 6,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
`ifdef DPRAM_STREAM_READER_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum,
  output logic          checksum_valid
`endif
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [AW-1:0] addr_q;
  logic [LW-1:0] issue_rem;
  logic [LW-1:0] xfer_rem;
  logic [RD_LAT-1:0] vld;
  logic [DW-1:0] fifo_mem [BUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ_total;
  logic          credit;
  logic          issue;
  logic          push;
  logic          fire;
  logic          done_q;
  logic          accept_run;
  logic          accept_empty;

  // Valid/ready: a word moves when out_valid && out_ready at a rising edge;
  // out_valid/out_data stay put while out_ready is low.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && length != '0) state_next = ISSUE;
      ISSUE:   if (issue && issue_rem == LW'(1)) state_next = DRAIN;
      DRAIN:   if (fire && xfer_rem == LW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    issue     = (state == ISSUE) && credit;
    out_valid = (count != '0);
    out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    fire      = out_valid && out_ready;
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_data  = '0;
    done      = done_q;
  end

  assign accept_run   = (state == IDLE) && start && (length != '0);
  assign accept_empty = (state == IDLE) && start && (length == '0);
  assign push         = vld[RD_LAT-1];

  // Credit counts words already buffered plus reads whose data is still on its way.
  always_comb begin
    occ_total = (CW+1)'(count);
    for (int i = 0; i < RD_LAT; i++) occ_total = occ_total + (CW+1)'(vld[i]);
    credit = occ_total < (CW+1)'(BUF_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      issue_rem <= '0;
      xfer_rem  <= '0;
      vld       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept_run) begin
        addr_q    <= base_addr;
        issue_rem <= length;
        xfer_rem  <= length;
      end else begin
        if (issue) begin
          issue_rem <= issue_rem - LW'(1);
          // Hold the last issued address so mem_addr stays quiet after the run.
          if (issue_rem != LW'(1)) addr_q <= addr_q + AW'(1);
        end
        if (fire) xfer_rem <= xfer_rem - LW'(1);
      end

      vld[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];

      if (push) wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (fire) rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      done_q <= accept_empty || ((state == DRAIN) && fire && (xfer_rem == LW'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_q;
  end

`ifdef DPRAM_STREAM_READER_CHECKSUM_EN
  logic [DW-1:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        csum_q <= '0;
    else if ((state == IDLE) && start) csum_q <= '0;
    else if (fire)                     csum_q <= csum_q ^ out_data;
  end

  assign checksum       = csum_q;
  assign checksum_valid = done_q;
`endif

  no_full_with_inflight: assert property (
    @(posedge clk) disable iff (!rst_n) !((count == CW'(BUF_DEPTH)) && (vld != '0))
  );

endmodule
